// File: rtl/parking_gate_arbiter.sv
// Single barrier gate controller: arbitrates entry/exit requests, sequences the password
// check, tracks occupancy and applies a lockout after repeated bad passwords.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY     = 8,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned OPEN_CYCLES  = 16,
  parameter int unsigned CLOSE_CYCLES = 4,
  parameter int unsigned AUTH_TIMEOUT = 32,
  parameter int unsigned MAX_FAIL     = 3,
  parameter int unsigned LOCK_CYCLES  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             auth_valid,
  input  logic             auth_ok,
  output logic             auth_req,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             entry_reject,
  output logic             exit_reject,
  output logic             gate_open,
  output logic             busy,
  output logic             lockout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  localparam int unsigned TMax01 = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
  localparam int unsigned TMax   = (TMax01 > AUTH_TIMEOUT) ? TMax01 : AUTH_TIMEOUT;
  localparam int unsigned TW     = $clog2(TMax + 1);
  localparam int unsigned FW     = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW     = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAuth,
    StOpenIn,
    StOpenOut,
    StClose
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic [FW-1:0]   fail_cnt_q;
  logic [LW-1:0]   lock_cnt_q;
  logic            last_exit_q;
  logic            entry_req_q;
  logic            exit_req_q;

  logic exit_ok;
  logic entry_ok;
  logic pick_exit;

  // Round-robin: on a tie, serve the side that was not served last.
  always_comb begin
    exit_ok   = exit_req & ~empty;
    entry_ok  = entry_req & ~full & ~lockout;
    pick_exit = exit_ok & (~entry_ok | ~last_exit_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      fail_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      last_exit_q  <= 1'b0;
      entry_req_q  <= 1'b0;
      exit_req_q   <= 1'b0;
      auth_req     <= 1'b0;
      entry_grant  <= 1'b0;
      exit_grant   <= 1'b0;
      entry_reject <= 1'b0;
      exit_reject  <= 1'b0;
      gate_open    <= 1'b0;
      busy         <= 1'b0;
      lockout      <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      occupancy    <= '0;
    end else begin
      entry_grant  <= 1'b0;
      exit_grant   <= 1'b0;
      entry_reject <= 1'b0;
      exit_reject  <= 1'b0;
      entry_req_q  <= entry_req;
      exit_req_q   <= exit_req;

      // Lock timer runs regardless of the gate state.
      if (lockout) begin
        if (lock_cnt_q == '0) begin
          lockout <= 1'b0;
        end else begin
          lock_cnt_q <= lock_cnt_q - LW'(1);
        end
      end

      case (state_q)
        StIdle: begin
          if (entry_req && !entry_req_q && (full || lockout)) begin
            entry_reject <= 1'b1;
          end
          if (exit_req && !exit_req_q && empty) begin
            exit_reject <= 1'b1;
          end
          if (pick_exit) begin
            state_q     <= StOpenOut;
            timer_q     <= '0;
            last_exit_q <= 1'b1;
            exit_grant  <= 1'b1;
            gate_open   <= 1'b1;
            busy        <= 1'b1;
            occupancy   <= occupancy - CNT_W'(1);
            full        <= 1'b0;
            empty       <= (occupancy == CNT_W'(1));
          end else if (entry_ok) begin
            state_q     <= StAuth;
            timer_q     <= '0;
            last_exit_q <= 1'b0;
            auth_req    <= 1'b1;
            busy        <= 1'b1;
          end
        end

        StAuth: begin
          if (auth_valid && auth_ok) begin
            state_q     <= StOpenIn;
            timer_q     <= '0;
            auth_req    <= 1'b0;
            entry_grant <= 1'b1;
            gate_open   <= 1'b1;
            fail_cnt_q  <= '0;
            occupancy   <= occupancy + CNT_W'(1);
            empty       <= 1'b0;
            full        <= (occupancy == CNT_W'(CAPACITY - 1));
          end else if (auth_valid) begin
            state_q  <= StIdle;
            auth_req <= 1'b0;
            busy     <= 1'b0;
            if (fail_cnt_q == FW'(MAX_FAIL - 1)) begin
              fail_cnt_q <= '0;
              lockout    <= 1'b1;
              lock_cnt_q <= LW'(LOCK_CYCLES - 1);
            end else begin
              fail_cnt_q <= fail_cnt_q + FW'(1);
            end
          end else if (timer_q == TW'(AUTH_TIMEOUT - 1)) begin
            // Abandoned attempt: not counted as a bad password.
            state_q  <= StIdle;
            auth_req <= 1'b0;
            busy     <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        StOpenIn, StOpenOut: begin
          if (timer_q == TW'(OPEN_CYCLES - 1)) begin
            state_q   <= StClose;
            timer_q   <= '0;
            gate_open <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        StClose: begin
          if (timer_q == TW'(CLOSE_CYCLES - 1)) begin
            state_q <= StIdle;
            timer_q <= '0;
            busy    <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        default: begin
          state_q   <= StIdle;
          timer_q   <= '0;
          auth_req  <= 1'b0;
          gate_open <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: default instance plus a CAPACITY=2 instance
// sharing the same stimulus.
module tb_parking_gate_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic entry_req = 1'b0;
  logic exit_req = 1'b0;
  logic auth_valid = 1'b0;
  logic auth_ok = 1'b0;

  logic auth_req, entry_grant, exit_grant, entry_reject, exit_reject;
  logic gate_open, busy, lockout, full, empty;
  logic [3:0] occupancy;

  logic auth_req_2, entry_grant_2, exit_grant_2, entry_reject_2, exit_reject_2;
  logic gate_open_2, busy_2, lockout_2, full_2, empty_2;
  logic [3:0] occupancy_2;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  parking_gate_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .auth_valid   (auth_valid),
    .auth_ok      (auth_ok),
    .auth_req     (auth_req),
    .entry_grant  (entry_grant),
    .exit_grant   (exit_grant),
    .entry_reject (entry_reject),
    .exit_reject  (exit_reject),
    .gate_open    (gate_open),
    .busy         (busy),
    .lockout      (lockout),
    .full         (full),
    .empty        (empty),
    .occupancy    (occupancy)
  );

  parking_gate_arbiter #(
    .CAPACITY (2)
  ) u_dut_cap2 (
    .clk          (clk),
    .rst          (rst),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .auth_valid   (auth_valid),
    .auth_ok      (auth_ok),
    .auth_req     (auth_req_2),
    .entry_grant  (entry_grant_2),
    .exit_grant   (exit_grant_2),
    .entry_reject (entry_reject_2),
    .exit_reject  (exit_reject_2),
    .gate_open    (gate_open_2),
    .busy         (busy_2),
    .lockout      (lockout_2),
    .full         (full_2),
    .empty        (empty_2),
    .occupancy    (occupancy_2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    auth_valid = 1'b0;
    auth_ok = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_reset();
    rst = 1'b1;
  endtask

  task automatic wait_auth();
    for (int i = 0; i < 10 && !auth_req; i++) tick();
    n_tests++;
    if (auth_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_auth: auth_req=%b required 1 within 10 cycles", auth_req);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b required 0 within 60 cycles", busy);
    end
  endtask

  task automatic admit_entry();
    entry_req = 1'b1;
    wait_auth();
    auth_valid = 1'b1;
    auth_ok = 1'b1;
    tick();
    auth_valid = 1'b0;
    auth_ok = 1'b0;
    entry_req = 1'b0;
    wait_idle();
  endtask

  task automatic fail_entry();
    entry_req = 1'b1;
    wait_auth();
    auth_valid = 1'b1;
    auth_ok = 1'b0;
    tick();
    auth_valid = 1'b0;
    entry_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    apply_reset();
    flags = {auth_req, entry_grant, exit_grant, entry_reject, exit_reject,
             gate_open, busy, lockout, full, empty};
    n_tests++;
    if (flags !== 10'b0000000001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000001", flags);
    end
    n_tests++;
    if (occupancy !== 4'd0 || occupancy_2 !== 4'd0 || empty_2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_occ: occ=%0d occ2=%0d empty2=%b required 0 0 1",
               occupancy, occupancy_2, empty_2);
    end
    release_reset();
  endtask

  task automatic test_entry_grant();
    int n;
    apply_reset();
    release_reset();
    entry_req = 1'b1;
    tick();
    n_tests++;
    if (auth_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL entry_auth: auth_req=%b busy=%b required 1 1", auth_req, busy);
    end
    tick();
    tick();
    auth_valid = 1'b1;
    auth_ok = 1'b1;
    tick();
    n_tests++;
    if ({entry_grant, gate_open, auth_req, empty} !== 4'b1100 || occupancy !== 4'd1) begin
      n_fail++;
      $display("FAIL entry_grant: grant/gate/auth/empty=%b occ=%0d required 1100 1",
               {entry_grant, gate_open, auth_req, empty}, occupancy);
    end
    auth_valid = 1'b0;
    auth_ok = 1'b0;
    entry_req = 1'b0;
    n = 1;
    tick();
    n_tests++;
    if (entry_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_grant_pulse: entry_grant=%b required 0", entry_grant);
    end
    while (gate_open && n < 40) begin
      n++;
      tick();
    end
    n_tests++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL gate_open_len: %0d cycles required 16", n);
    end
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL close_len: busy low after %0d cycles required 4", n);
    end
  endtask

  task automatic test_exit_reject_empty();
    apply_reset();
    release_reset();
    exit_req = 1'b1;
    tick();
    n_tests++;
    if ({exit_reject, exit_grant, busy, gate_open} !== 4'b1000) begin
      n_fail++;
      $display("FAIL exit_reject: rej/grant/busy/gate=%b required 1000",
               {exit_reject, exit_grant, busy, gate_open});
    end
    tick();
    n_tests++;
    if ({exit_reject, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL exit_reject_pulse: rej/busy=%b required 00", {exit_reject, busy});
    end
    exit_req = 1'b0;
    tick();
  endtask

  task automatic test_auth_timeout();
    int n;
    apply_reset();
    release_reset();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    n = 1;
    for (int i = 0; i < 100 && auth_req; i++) begin
      tick();
      if (auth_req) n++;
    end
    n_tests++;
    if (n !== 32 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL auth_timeout: auth_req for %0d cycles busy=%b required 32 0", n, busy);
    end
    fail_entry();
    fail_entry();
    n_tests++;
    if (lockout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_not_counted: lockout=%b required 0", lockout);
    end
  endtask

  task automatic test_lockout();
    int t0;
    apply_reset();
    release_reset();
    admit_entry();
    fail_entry();
    fail_entry();
    n_tests++;
    if (lockout !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: lockout=%b after 2 fails required 0", lockout);
    end
    entry_req = 1'b1;
    wait_auth();
    auth_valid = 1'b1;
    auth_ok = 1'b0;
    tick();
    t0 = cyc;
    n_tests++;
    if ({lockout, auth_req, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL lock_set: lock/auth/busy=%b required 100", {lockout, auth_req, busy});
    end
    auth_valid = 1'b0;
    entry_req = 1'b0;
    tick();
    entry_req = 1'b1;
    tick();
    n_tests++;
    if ({entry_reject, auth_req, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL lock_reject: rej/auth/busy=%b required 100",
               {entry_reject, auth_req, busy});
    end
    exit_req = 1'b1;
    tick();
    n_tests++;
    if ({exit_grant, gate_open, entry_reject, auth_req} !== 4'b1100 || occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL lock_exit: grant/gate/rej/auth=%b occ=%0d required 1100 0",
               {exit_grant, gate_open, entry_reject, auth_req}, occupancy);
    end
    exit_req = 1'b0;
    entry_req = 1'b0;
    for (int i = 0; i < 200 && lockout; i++) tick();
    n_tests++;
    if (lockout !== 1'b0 || (cyc - t0) !== 64) begin
      n_fail++;
      $display("FAIL lock_len: lockout=%b held %0d cycles required 0 64", lockout, cyc - t0);
    end
  endtask

  task automatic test_tie();
    apply_reset();
    release_reset();
    admit_entry();
    admit_entry();
    n_tests++;
    if (occupancy !== 4'd2) begin
      n_fail++;
      $display("FAIL tie_fill: occ=%0d required 2", occupancy);
    end
    entry_req = 1'b1;
    exit_req = 1'b1;
    tick();
    n_tests++;
    if ({exit_grant, entry_grant, auth_req} !== 3'b100 || occupancy !== 4'd1) begin
      n_fail++;
      $display("FAIL tie_exit_first: xg/eg/auth=%b occ=%0d required 100 1",
               {exit_grant, entry_grant, auth_req}, occupancy);
    end
    exit_req = 1'b0;
    wait_idle();
    tick();
    n_tests++;
    if (auth_req !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_entry_next: auth_req=%b required 1", auth_req);
    end
    auth_valid = 1'b1;
    auth_ok = 1'b1;
    tick();
    auth_valid = 1'b0;
    auth_ok = 1'b0;
    entry_req = 1'b0;
    n_tests++;
    if (entry_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_entry_grant: entry_grant=%b required 1", entry_grant);
    end
    wait_idle();
    n_tests++;
    if (occupancy !== 4'd2) begin
      n_fail++;
      $display("FAIL tie_final: occ=%0d required 2", occupancy);
    end
  endtask

  task automatic test_capacity();
    apply_reset();
    release_reset();
    admit_entry();
    admit_entry();
    n_tests++;
    if ({full_2, empty_2} !== 2'b10 || occupancy_2 !== 4'd2) begin
      n_fail++;
      $display("FAIL cap_full: full/empty=%b occ=%0d required 10 2",
               {full_2, empty_2}, occupancy_2);
    end
    entry_req = 1'b1;
    tick();
    n_tests++;
    if ({entry_reject_2, auth_req_2, busy_2} !== 3'b100) begin
      n_fail++;
      $display("FAIL cap_reject: rej/auth/busy=%b required 100",
               {entry_reject_2, auth_req_2, busy_2});
    end
    tick();
    n_tests++;
    if ({entry_reject_2, auth_req_2} !== 2'b00) begin
      n_fail++;
      $display("FAIL cap_reject_pulse: rej/auth=%b required 00", {entry_reject_2, auth_req_2});
    end
    entry_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_open();
    apply_reset();
    release_reset();
    entry_req = 1'b1;
    wait_auth();
    auth_valid = 1'b1;
    auth_ok = 1'b1;
    tick();
    auth_valid = 1'b0;
    auth_ok = 1'b0;
    entry_req = 1'b0;
    n_tests++;
    if (gate_open !== 1'b1 || occupancy !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_open: gate=%b occ=%0d required 1 1", gate_open, occupancy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({gate_open, busy, empty} !== 3'b001 || occupancy !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: gate/busy/empty=%b occ=%0d required 001 0",
               {gate_open, busy, empty}, occupancy);
    end
    rst = 1'b1;
    exit_req = 1'b1;
    tick();
    n_tests++;
    if ({exit_reject, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_reset_idle: rej/busy=%b required 10", {exit_reject, busy});
    end
    exit_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_entry_grant();
    test_exit_reject_empty();
    test_auth_timeout();
    test_lockout();
    test_tie();
    test_capacity();
    test_reset_mid_open();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
